// File: rtl/vendor_pkg.sv
// Shared types and constants for the multi-channel vending controller.
// Holds the state enum, coin codes, defaults and the price extractor.
package vendor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  localparam logic [1:0] COIN_LO = 2'b01;
  localparam logic [1:0] COIN_HI = 2'b10;

  localparam int MAX_DRINKS  = 8;
  localparam int PRICE_VEC_W = 128;

  localparam int DEF_NUM_DRINKS  = 2;
  localparam int DEF_CREDIT_W    = 6;
  localparam int DEF_COIN_LO_VAL = 2;
  localparam int DEF_COIN_HI_VAL = 20;
  localparam int DEF_MAX_CREDIT  = 32;
  localparam int DEF_STOCK_W     = 4;
  localparam int DEF_INIT_STOCK  = 5;
  localparam logic [11:0] DEF_PRICES = {6'd10, 6'd5};

  // Channel idx price out of a packed price vector of w-bit fields.
  function automatic logic [15:0] price_at(
    input logic [PRICE_VEC_W-1:0] p,
    input int idx,
    input int w
  );
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 16; b++)
      if (b < w) r[4'(b)] = p[7'(idx * w + b)];
    return r;
  endfunction

endpackage

// File: rtl/vendor_stock.sv
// Per-channel stock counters with decrement and restock ports.
// Ports: dec_i/dec_sel_i vend, load_i/load_sel_i refill, stock/empty flags.
module vendor_stock
  import vendor_pkg::*;
#(
  parameter int NUM_DRINKS = DEF_NUM_DRINKS,
  parameter int STOCK_W    = DEF_STOCK_W,
  parameter int INIT_STOCK = DEF_INIT_STOCK
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          dec_i,
  input  logic [2:0]                    dec_sel_i,
  input  logic                          load_i,
  input  logic [2:0]                    load_sel_i,
  output logic [NUM_DRINKS*STOCK_W-1:0] stock_o,
  output logic [NUM_DRINKS-1:0]         empty_o,
  output logic [NUM_DRINKS-1:0]         empty_nx_o
);

  localparam logic [STOCK_W-1:0] INIT_V = STOCK_W'(INIT_STOCK);

  logic [STOCK_W-1:0] cnt_q [NUM_DRINKS];
  logic [STOCK_W-1:0] cnt_d [NUM_DRINKS];

  // Out-of-range selects match no channel, so they are dropped here.
  always_comb begin
    for (int i = 0; i < NUM_DRINKS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (load_i && load_sel_i == 3'(i))
        cnt_d[i] = INIT_V;
      else if (dec_i && dec_sel_i == 3'(i) && cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_DRINKS; i++)
        cnt_q[i] <= INIT_V;
    end else begin
      for (int i = 0; i < NUM_DRINKS; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_DRINKS; g++) begin : g_out
    assign stock_o[g*STOCK_W +: STOCK_W] = cnt_q[g];
    assign empty_o[g]    = (cnt_q[g] == '0);
    assign empty_nx_o[g] = (cnt_d[g] == '0);
  end

endmodule

// File: rtl/vendor_multi.sv
// N-channel vending controller: credit FSM, vend/refund, status pulses.
// Strobes in (coin/op/cancel/ack/restock); display, actuator, pulse outs.
module vendor_multi
  import vendor_pkg::*;
#(
  parameter int NUM_DRINKS  = DEF_NUM_DRINKS,
  parameter int CREDIT_W    = DEF_CREDIT_W,
  parameter logic [NUM_DRINKS*CREDIT_W-1:0] PRICES = DEF_PRICES,
  parameter int COIN_LO_VAL = DEF_COIN_LO_VAL,
  parameter int COIN_HI_VAL = DEF_COIN_HI_VAL,
  parameter int MAX_CREDIT  = DEF_MAX_CREDIT,
  parameter int STOCK_W     = DEF_STOCK_W,
  parameter int INIT_STOCK  = DEF_INIT_STOCK
) (
  input  logic                          clk_N,
  input  logic                          reset,
  input  logic                          coin_in,
  input  logic [1:0]                    coin_type,
  input  logic                          op_start,
  input  logic [2:0]                    drink_sel,
  input  logic                          cancel_flag,
  input  logic                          change_ack,
  input  logic                          restock,
  input  logic [2:0]                    restock_sel,
  output logic                          open,
  output logic [1:0]                    moore_state,
  output logic [CREDIT_W-1:0]           credit_val,
  output logic [NUM_DRINKS-1:0]         afford,
  output logic [NUM_DRINKS*STOCK_W-1:0] stock,
  output logic                          dispense,
  output logic [2:0]                    dispense_id,
  output logic                          change_valid,
  output logic [CREDIT_W-1:0]           change_val,
  output logic                          coin_reject,
  output logic                          over_flow,
  output logic                          no_money,
  output logic                          no_num
);

  localparam int CW1 = CREDIT_W + 1;
  localparam logic [CW1-1:0] LO_V  = CW1'(COIN_LO_VAL);
  localparam logic [CW1-1:0] HI_V  = CW1'(COIN_HI_VAL);
  localparam logic [CW1-1:0] MAX_V = CW1'(MAX_CREDIT);

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  open_q;
  logic                  disp_q, disp_d;
  logic [2:0]            disp_id_q, disp_id_d;
  logic                  chg_valid_q, chg_valid_d;
  logic [CREDIT_W-1:0]   chg_val_q, chg_val_d;
  logic                  rej_q, rej_d;
  logic                  ovf_q, ovf_d;
  logic                  nomon_q, nomon_d;
  logic                  nonum_q, nonum_d;
  logic [NUM_DRINKS-1:0] afford_q, afford_d;

  logic [CREDIT_W-1:0]   price_a [MAX_DRINKS];
  logic [MAX_DRINKS-1:0] empty_ext;
  logic [NUM_DRINKS-1:0] empty_w, empty_nx_w;
  logic                  rest_en;
  logic                  coin_ok;
  logic [CW1-1:0]        coin_v;
  logic [CW1-1:0]        sum;
  logic                  sel_ok;

  // Channels past NUM_DRINKS read as empty and free.
  for (genvar g = 0; g < MAX_DRINKS; g++) begin : g_ch
    if (g < NUM_DRINKS) begin : g_v
      assign price_a[g] =
        CREDIT_W'(price_at(PRICE_VEC_W'(PRICES), g, CREDIT_W));
      assign empty_ext[g] = empty_w[g];
    end else begin : g_n
      assign price_a[g]   = '0;
      assign empty_ext[g] = 1'b1;
    end
  end

  assign sel_ok = ({1'b0, drink_sel} < 4'(NUM_DRINKS));

  vendor_stock #(
    .NUM_DRINKS (NUM_DRINKS),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk_i      (clk_N),
    .rst_ni     (reset),
    .dec_i      (state_q == VEND),
    .dec_sel_i  (disp_id_q),
    .load_i     (rest_en),
    .load_sel_i (restock_sel),
    .stock_o    (stock),
    .empty_o    (empty_w),
    .empty_nx_o (empty_nx_w)
  );

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    disp_d      = 1'b0;
    disp_id_d   = '0;
    chg_valid_d = chg_valid_q;
    chg_val_d   = chg_val_q;
    rej_d       = 1'b0;
    ovf_d       = 1'b0;
    nomon_d     = 1'b0;
    nonum_d     = 1'b0;
    rest_en     = 1'b0;
    coin_ok     = 1'b0;
    coin_v      = '0;
    sum         = '0;
    unique case (state_q)
      IDLE, CREDIT: begin
        rest_en = restock;
        if (coin_in) begin
          case (coin_type)
            COIN_LO: begin coin_ok = 1'b1; coin_v = LO_V; end
            COIN_HI: begin coin_ok = 1'b1; coin_v = HI_V; end
            default: coin_ok = 1'b0;
          endcase
          // One extra bit so the ceiling test cannot wrap.
          sum = {1'b0, credit_q} + coin_v;
          if (!coin_ok) begin
            rej_d = 1'b1;
          end else if (sum > MAX_V) begin
            ovf_d = 1'b1;
            rej_d = 1'b1;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end
        end else if (op_start) begin
          if (!sel_ok || empty_ext[drink_sel]) begin
            nonum_d = 1'b1;
          end else if ({1'b0, credit_q} <
                       {1'b0, price_a[drink_sel]}) begin
            nomon_d = 1'b1;
          end else begin
            state_d   = VEND;
            disp_d    = 1'b1;
            disp_id_d = drink_sel;
          end
        end else if (cancel_flag && credit_q != '0) begin
          state_d     = CHANGE;
          chg_valid_d = 1'b1;
          chg_val_d   = credit_q;
        end
      end
      VEND: begin
        rej_d    = coin_in;
        credit_d = credit_q - price_a[disp_id_q];
        state_d  = (credit_d == '0) ? IDLE : CREDIT;
      end
      CHANGE: begin
        rej_d = coin_in;
        if (change_ack) begin
          credit_d    = '0;
          chg_valid_d = 1'b0;
          chg_val_d   = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered against next credit/stock so it lines up with credit_val.
  for (genvar g = 0; g < NUM_DRINKS; g++) begin : g_aff
    assign afford_d[g] =
      ({1'b0, credit_d} >= {1'b0, price_a[g]}) && !empty_nx_w[g];
  end

  always_ff @(posedge clk_N or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      open_q      <= 1'b0;
      disp_q      <= 1'b0;
      disp_id_q   <= '0;
      chg_valid_q <= 1'b0;
      chg_val_q   <= '0;
      rej_q       <= 1'b0;
      ovf_q       <= 1'b0;
      nomon_q     <= 1'b0;
      nonum_q     <= 1'b0;
      afford_q    <= '0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      open_q      <= 1'b1;
      disp_q      <= disp_d;
      disp_id_q   <= disp_id_d;
      chg_valid_q <= chg_valid_d;
      chg_val_q   <= chg_val_d;
      rej_q       <= rej_d;
      ovf_q       <= ovf_d;
      nomon_q     <= nomon_d;
      nonum_q     <= nonum_d;
      afford_q    <= afford_d;
    end
  end

  assign open         = open_q;
  assign moore_state  = state_q;
  assign credit_val   = credit_q;
  assign afford       = afford_q;
  assign dispense     = disp_q;
  assign dispense_id  = disp_id_q;
  assign change_valid = chg_valid_q;
  assign change_val   = chg_val_q;
  assign coin_reject  = rej_q;
  assign over_flow    = ovf_q;
  assign no_money     = nomon_q;
  assign no_num       = nonum_q;

endmodule
